// File: rtl/fifo_ser_pkg.sv
// Shared definitions for the word-to-bit serializer that feeds the serial bit-FIFO.
//   ser_state_t : serializer FSM states
//   WORDS_W     : width of the completed-word counter
//   cnt_width() : bit-counter width able to count both word bits and pad bits
package fifo_ser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        PAD   = 2'd3
    } ser_state_t;

    localparam int WORDS_W = 16;

    // The shared counter must reach max(W, D) - 1, so size it for the larger of the two.
    function automatic int cnt_width(input int w, input int d);
        int m;
        m = (w > d) ? w : d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/fifo_word_serializer_parity_gen.sv
// Even-parity generator: XOR reduction of a W-bit word.
//   data   : word to protect
//   parity : 1 when data holds an odd number of ones
module ser_parity_gen #(
    parameter int W = 8
) (
    input  logic [W-1:0] data,
    output logic         parity
);

    assign parity = ^data;

endmodule

// File: rtl/fifo_word_serializer.sv
// Parallel-to-serial feeder for the serial bit-FIFO. Words arrive on a valid/ready
// handshake and leave LSB-first, one bit per clock with a write strobe, optionally
// followed by an even-parity bit. A flush request appends D zero bits so the last
// real word is pushed through the downstream delay line.
//   clk, rst             : clock, asynchronous active-low reset
//   s_data/s_valid       : parallel word input; s_ready high only in IDLE
//   flush                : one-cycle pad request, remembered until served
//   ser_bit/ser_write_en : registered serial output and strobe
//   busy                 : any state other than IDLE
//   words_sent           : completed words, wraps modulo 2^16
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int W         = 8,
    parameter int D         = 4,
    parameter int PARITY_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W-1:0]       s_data,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               flush,
    output logic               ser_bit,
    output logic               ser_write_en,
    output logic               busy,
    output logic [WORDS_W-1:0] words_sent
);

    localparam int              CNT_W    = cnt_width(W, D);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] LAST_PAD = CNT_W'(D - 1);

    ser_state_t         state_r, state_s;
    logic [W-1:0]       shreg_r, shreg_s;
    logic               par_r, par_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               pend_r, pend_s;
    logic [WORDS_W-1:0] words_r, words_s;
    logic               bit_r, bit_s;
    logic               we_r, we_s;
    logic               cap_par_s;
    logic               pending_s;

    ser_parity_gen #(.W(W)) u_parity (
        .data   (s_data),
        .parity (cap_par_s)
    );

    // A flush arriving this cycle counts as already pending for this cycle's decision.
    assign pending_s = pend_r | flush;

    // Next-state, datapath and next-output decode; outputs are computed for the
    // state being entered so the registered strobe lines up with that state.
    always_comb begin
        state_s = state_r;
        shreg_s = shreg_r;
        par_s   = par_r;
        cnt_s   = cnt_r;
        pend_s  = pending_s;
        words_s = words_r;
        bit_s   = 1'b0;
        we_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (s_valid) begin
                    state_s = SHIFT;
                    shreg_s = s_data;
                    par_s   = cap_par_s;
                    cnt_s   = '0;
                    we_s    = 1'b1;
                    bit_s   = s_data[0];
                end else if (pending_s) begin
                    state_s = PAD;
                    cnt_s   = '0;
                    we_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_r == LAST_BIT) begin
                    cnt_s = '0;
                    if (PARITY_EN != 0) begin
                        state_s = PAR;
                        we_s    = 1'b1;
                        bit_s   = par_r;
                    end else begin
                        words_s = words_r + WORDS_W'(1);
                        if (pending_s) begin
                            state_s = PAD;
                            we_s    = 1'b1;
                        end else begin
                            state_s = IDLE;
                        end
                    end
                end else begin
                    shreg_s = {1'b0, shreg_r[W-1:1]};
                    cnt_s   = cnt_r + CNT_W'(1);
                    we_s    = 1'b1;
                    bit_s   = shreg_r[1];
                end
            end
            PAR: begin
                words_s = words_r + WORDS_W'(1);
                cnt_s   = '0;
                if (pending_s) begin
                    state_s = PAD;
                    we_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            PAD: begin
                // The running pad run satisfies any flush that arrives during it.
                pend_s = 1'b0;
                if (cnt_r == LAST_PAD) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                    we_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
                pend_s  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any word or pad run at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            shreg_r <= '0;
            par_r   <= 1'b0;
            cnt_r   <= '0;
            pend_r  <= 1'b0;
            words_r <= '0;
            bit_r   <= 1'b0;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            shreg_r <= shreg_s;
            par_r   <= par_s;
            cnt_r   <= cnt_s;
            pend_r  <= pend_s;
            words_r <= words_s;
            bit_r   <= bit_s;
            we_r    <= we_s;
        end
    end

    assign s_ready      = (state_r == IDLE);
    assign busy         = (state_r != IDLE);
    assign ser_bit      = bit_r;
    assign ser_write_en = we_r;
    assign words_sent   = words_r;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench for fifo_word_serializer (W=8, D=4, PARITY_EN=1): a table of words
// with hand-computed serial streams, plus hand-written multi-cycle sequences.
module tb_fifo_word_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        flush;
    logic        ser_bit;
    logic        ser_write_en;
    logic        busy;
    logic [15:0] words_sent;

    int vec_cnt = 0;
    int miscmp  = 0;

    typedef struct {
        logic [7:0]  data;
        logic        fl;
        int          len;
        logic [31:0] seq;
        logic [15:0] words;
    } vec_t;

    vec_t tbl[5];

    fifo_word_serializer #(.W(8), .D(4), .PARITY_EN(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .flush        (flush),
        .ser_bit      (ser_bit),
        .ser_write_en (ser_write_en),
        .busy         (busy),
        .words_sent   (words_sent)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one word (optionally with flush) and record every strobed bit in a 20-cycle window.
    task automatic send_collect(input logic [7:0] d, input logic fl,
                                output int n, output int nrdy, output logic [31:0] bits);
        n    = 0;
        nrdy = 0;
        bits = '0;
        chk("ready_before_send", {31'd0, s_ready}, 32'd1);
        s_data  = d;
        s_valid = 1'b1;
        flush   = fl;
        tick();
        s_valid = 1'b0;
        flush   = 1'b0;
        s_data  = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            if (ser_write_en) begin
                if (n < 32) bits[n] = ser_bit;
                n++;
            end
            if (!s_ready) nrdy++;
            tick();
        end
    endtask

    initial begin
        int          n;
        int          nrdy;
        logic [31:0] bits;
        logic [31:0] we_seq;
        logic [31:0] bit_seq;
        logic [31:0] busy_seq;

        // data, flush, strobe count, stream (bit i = i-th strobe), words_sent afterwards
        tbl[0] = '{8'hA5, 1'b0, 9,  32'h0000_00A5, 16'd1};
        tbl[1] = '{8'h80, 1'b0, 9,  32'h0000_0180, 16'd2};
        tbl[2] = '{8'h07, 1'b0, 9,  32'h0000_0107, 16'd3};
        tbl[3] = '{8'h3C, 1'b1, 13, 32'h0000_003C, 16'd4};
        tbl[4] = '{8'h00, 1'b1, 13, 32'h0000_0000, 16'd5};

        // Reset held with random inputs.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_data  = 8'($urandom);
            s_valid = 1'($urandom);
            flush   = 1'($urandom);
            tick();
        end
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_we", {31'd0, ser_write_en}, 32'd0);
        chk("rst_bit", {31'd0, ser_bit}, 32'd0);
        chk("rst_words", {16'd0, words_sent}, 32'd0);
        s_valid = 1'b0;
        flush   = 1'b0;
        rst     = 1'b1;
        tick();
        tick();
        chk("idle_after_rst_we", {31'd0, ser_write_en}, 32'd0);

        // Table-driven words.
        for (int v = 0; v < 5; v++) begin
            send_collect(tbl[v].data, tbl[v].fl, n, nrdy, bits);
            chk($sformatf("vec%0d_len", v), n, tbl[v].len);
            chk($sformatf("vec%0d_bits", v), bits, tbl[v].seq);
            chk($sformatf("vec%0d_notready", v), nrdy, tbl[v].len);
            chk($sformatf("vec%0d_words", v), {16'd0, words_sent}, {16'd0, tbl[v].words});
            chk($sformatf("vec%0d_idle", v), {31'd0, busy}, 32'd0);
        end

        // Back-to-back 0x01 then 0xFF with s_valid held high: one gap cycle between words.
        s_data  = 8'h01;
        s_valid = 1'b1;
        tick();
        s_data  = 8'hFF;
        we_seq  = '0;
        bit_seq = '0;
        for (int i = 0; i < 20; i++) begin
            we_seq[i]  = ser_write_en;
            bit_seq[i] = ser_bit;
            tick();
            if (i == 9) s_valid = 1'b0;
        end
        s_valid = 1'b0;
        chk("b2b_we", we_seq, 32'h0007_FDFF);
        chk("b2b_bits", bit_seq, 32'h0003_FD01);
        chk("b2b_words", {16'd0, words_sent}, 32'd7);

        // Flush alone in IDLE: four zero pads, count unchanged.
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        we_seq   = '0;
        bit_seq  = '0;
        busy_seq = '0;
        for (int i = 0; i < 8; i++) begin
            we_seq[i]   = ser_write_en;
            bit_seq[i]  = ser_bit;
            busy_seq[i] = busy;
            tick();
        end
        chk("flush_we", we_seq, 32'h0000_000F);
        chk("flush_bits", bit_seq, 32'h0000_0000);
        chk("flush_busy", busy_seq, 32'h0000_000F);
        chk("flush_words", {16'd0, words_sent}, 32'd7);

        // Second flush during PAD is absorbed: still exactly four pads, none afterwards.
        flush = 1'b1;
        tick();
        flush  = 1'b0;
        we_seq = '0;
        for (int i = 0; i < 12; i++) begin
            we_seq[i] = ser_write_en;
            flush     = (i == 1);
            tick();
            flush     = 1'b0;
        end
        chk("reflush_we", we_seq, 32'h0000_000F);

        // Reset after three bits of 0xF0 drops the strobe at once and clears the count.
        s_data  = 8'hF0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("midrst_we", {31'd0, ser_write_en}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_words", {16'd0, words_sent}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        send_collect(8'h0F, 1'b0, n, nrdy, bits);
        chk("post_rst_len", n, 32'd9);
        chk("post_rst_bits", bits, 32'h0000_000F);
        chk("post_rst_words", {16'd0, words_sent}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule

// File: doc/fifo_word_serializer.md
# fifo_word_serializer

Upstream feeder for the team's serial bit-FIFO (1-bit shift delay line of depth D with `in`/`write_en`). It accepts parallel W-bit words over a valid/ready handshake and emits them LSB-first as one bit per clock with a write strobe, optionally followed by an even-parity bit. On request it also emits D zero pad bits, so the last real word is pushed fully through the downstream delay line.

## Interface
- `W`, default 8: word width; must be ≥ 2.
- `D`, default 4: downstream FIFO depth; equals the number of pad bits per flush; must be ≥ 1.
- `PARITY_EN`, default 1: 1 appends an even-parity bit after each word; 0 omits it.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `s_data`  in  W  parallel word.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  block can accept a word; high exactly when the state is IDLE.
- `flush`  in  1  single-cycle request to emit D pad bits.
- `ser_bit`  out  1  serial data; connects to the FIFO `in`.
- `ser_write_en`  out  1  bit strobe; connects to the FIFO `write_en`.
- `busy`  out  1  high in any state other than IDLE.
- `words_sent`  out  16  count of completed words; wraps modulo 2^16.

## Operation
- States: IDLE, SHIFT, PAR, PAD.
- **IDLE**
  - `s_ready`=1, `ser_write_en`=0, `ser_bit`=0.
  - `s_valid`&&`s_ready` captures `s_data` into the shift register and a parity register (XOR of all bits), then moves to SHIFT.
  - Otherwise, if flush is pending, moves to PAD.
- **SHIFT**
  - Each cycle: `ser_write_en`=1, `ser_bit`=shreg[0], shreg shifts right, bit counter increments.
  - After the W-th bit: go to PAR if `PARITY_EN`, else finish the word.
- **PAR**
  - One cycle with `ser_write_en`=1 and `ser_bit`=parity, where parity = XOR of the word (even parity).
  - Then finish the word.
- **Finish word**
  - `words_sent` += 1 on the cycle the last bit of the word is emitted.
  - Next state is PAD if flush is pending, else IDLE.
- **PAD**
  - D cycles with `ser_write_en`=1 and `ser_bit`=0.
  - Clears the pending flag, then returns to IDLE.
- **Flush handling**
  - A `flush` pulse in any state sets the pending flag.
  - A `flush` pulse during PAD is absorbed by the current pad run; no second run.
  - `flush` and an accepted word in the same IDLE cycle: the word is serialized first, then PAD.
- `ser_bit` and `ser_write_en` are registered outputs, driven from state and shift register flops.
- `s_ready` and `busy` are decoded from the state register only; they have no combinational path from inputs.
- `s_data` is ignored outside the accepting cycle and may change freely.

## Timing
- **Reset values**
  - While `rst`=0: state IDLE, `s_ready`=1, `busy`=0, `ser_bit`=0, `ser_write_en`=0, `words_sent`=0, flush pending cleared.
  - Reset asserted mid-word or mid-pad aborts at once: the partial word is dropped, no count increment, and the strobe is low from the reset edge.
- Latency: a word accepted at edge N gives its first `ser_write_en`=1 in cycle N+1.
- Word period: W + `PARITY_EN` strobe cycles plus one IDLE cycle, i.e. back-to-back words have exactly one gap cycle with `ser_write_en`=0.
- Flush in IDLE at edge N: pad strobes in cycles N+1 … N+D.
- `words_sent` rolls 0xFFFF → 0x0000 with no flag.

## Structure
- **Package `fifo_ser_pkg`** holds:
  - the state enum `ser_state_t` (IDLE, SHIFT, PAR, PAD);
  - a helper for counter width: CNT_W = $clog2(max(W, D) + 1);
  - the width constant 16 for `words_sent`.
- One shared bit counter serves both SHIFT and PAD; it is cleared on every state entry.
- The natural sub-module is `ser_parity_gen`: a combinational XOR reduction of W bits, instantiated once at capture. Everything else is inline.

## Test plan
All scenarios use W=8, D=4, PARITY_EN=1.
- **Reset:** hold `rst`=0 with random inputs → `s_ready`=1, `busy`=0, `ser_write_en`=0, `ser_bit`=0, `words_sent`=0.
- **Single word:** send 0xA5 → 9 consecutive strobes with bits 1,0,1,0,0,1,0,1 then parity 0; `words_sent`=1; `s_ready` low for exactly those 9 cycles.
- **Back-to-back words:** 0x01 then 0xFF with `s_valid` held high → bits 1,0,0,0,0,0,0,0,p=1, one idle cycle, eight 1s, p=0; `words_sent`=2.
- **Flush alone:** pulse `flush` in IDLE → 4 strobes with `ser_bit`=0, `busy` high for 4 cycles, `words_sent` unchanged.
- **Flush with word, plus repeat flush:** pulse `flush` together with an accepted 0x3C → 0,0,1,1,1,1,0,0,p=0, then 4 pad zeros. A second `flush` during PAD produces no extra pads.
- **Reset mid-word:** assert `rst` after 3 bits of 0xF0 → strobe drops immediately and `words_sent`=0. After release, sending 0x0F gives a clean 9-bit sequence 1,1,1,1,0,0,0,0,0.
